// File: rtl/shift_sched.sv
// shift_sched: two requesters share one serial logical right shifter.
// Each shift job is granted round-robin and shifts one bit per cycle.
// The result is then held until the consumer accepts it.
module shift_sched #(
   parameter int W    = 8,
   parameter int AMTW = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req0_valid,
   input  logic [W-1:0]    req0_data,
   input  logic [AMTW-1:0] req0_amt,
   output logic            req0_ready,
   input  logic            req1_valid,
   input  logic [W-1:0]    req1_data,
   input  logic [AMTW-1:0] req1_amt,
   output logic            req1_ready,
   output logic            rsp_valid,
   output logic [W-1:0]    rsp_data,
   output logic            rsp_id,
   input  logic            rsp_ready,
   output logic            busy
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t          r_state;
   state_t          w_next;
   logic [W-1:0]    r_data;
   logic [AMTW-1:0] r_cnt;
   logic            r_id;
   logic            r_last;
   logic            w_grant;
   logic            w_idle;
   logic            w_accept;
   logic [W-1:0]    w_sel_data;
   logic [AMTW-1:0] w_sel_amt;

   // Round-robin grant and combinational ready, only offered while idle
   always_comb begin
      w_grant = 1'b0;
      if (req0_valid && req1_valid) begin
         w_grant = ~r_last;
      end else if (req1_valid) begin
         w_grant = 1'b1;
      end
      w_idle     = (r_state == IDLE);
      req0_ready = w_idle & req0_valid & ~w_grant;
      req1_ready = w_idle & req1_valid & w_grant;
      w_accept   = req0_ready | req1_ready;
      w_sel_data = w_grant ? req1_data : req0_data;
      w_sel_amt  = w_grant ? req1_amt  : req0_amt;
   end

   // Next-state decode for the IDLE -> SHIFT -> DONE job sequence
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_next = (w_sel_amt == '0) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            if (r_cnt == AMTW'(1)) begin
               w_next = DONE;
            end
         end
         DONE: begin
            if (rsp_ready) begin
               w_next = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Shared datapath: capture on accept, shift per SHIFT cycle, retire grant on handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data <= '0;
         r_cnt  <= '0;
         r_id   <= 1'b0;
         r_last <= 1'b1;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_data <= w_sel_data;
                  r_cnt  <= w_sel_amt;
                  r_id   <= w_grant;
               end
            end
            SHIFT: begin
               r_data <= {1'b0, r_data[W-1:1]};
               r_cnt  <= r_cnt - AMTW'(1);
            end
            DONE: begin
               if (rsp_ready) begin
                  r_last <= r_id;
               end
            end
            default: ;
         endcase
      end
   end

   // Response outputs are forced to zero outside DONE
   always_comb begin
      rsp_valid = (r_state == DONE);
      rsp_data  = rsp_valid ? r_data : '0;
      rsp_id    = rsp_valid & r_id;
      busy      = (r_state != IDLE);
   end

endmodule

// File: tb/tb_shift_sched.sv
// Bench for shift_sched: directed scenarios followed by random jobs.
// Results are predicted from data >> amt, latency amt+1 and round-robin rules.
module tb_shift_sched;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req0_valid, req1_valid;
   logic [7:0] req0_data, req1_data;
   logic [2:0] req0_amt, req1_amt;
   logic       req0_ready, req1_ready;
   logic       rsp_valid;
   logic [7:0] rsp_data;
   logic       rsp_id;
   logic       rsp_ready;
   logic       busy;

   int n_checks = 0;
   int n_pass   = 0;
   int m_last   = 1;

   shift_sched #(.W(8), .AMTW(3)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_data  (req0_data),
      .req0_amt   (req0_amt),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_data  (req1_data),
      .req1_amt   (req1_amt),
      .req1_ready (req1_ready),
      .rsp_valid  (rsp_valid),
      .rsp_data   (rsp_data),
      .rsp_id     (rsp_id),
      .rsp_ready  (rsp_ready),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One complete job: present requests, predict grant, time the result, apply backpressure
   task automatic do_job(input bit v0, input bit v1,
                         input logic [7:0] d0, input logic [7:0] d1,
                         input logic [2:0] a0, input logic [2:0] a1,
                         input int bp);
      int g;
      int lat;
      logic [7:0] ed;
      int ea;
      req0_valid = v0; req0_data = d0; req0_amt = a0;
      req1_valid = v1; req1_data = d1; req1_amt = a1;
      rsp_ready  = 1'b0;
      #1;
      if (v0 && v1) g = (m_last == 0) ? 1 : 0;
      else          g = v1 ? 1 : 0;
      ea = (g == 1) ? int'(a1) : int'(a0);
      ed = ((g == 1) ? d1 : d0) >> ea;
      chk("ready0_grant", req0_ready, (v0 && g == 0) ? 1 : 0);
      chk("ready1_grant", req1_ready, (v1 && g == 1) ? 1 : 0);
      chk("idle_busy", busy, 0);
      chk("idle_rsp_valid", rsp_valid, 0);
      step();
      if (g == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 20) begin
         chk("shift_busy", busy, 1);
         chk("shift_rsp_data", rsp_data, 0);
         chk("shift_ready0", req0_ready, 0);
         chk("shift_ready1", req1_ready, 0);
         step();
         lat++;
      end
      chk("latency", lat, ea + 1);
      chk("done_data", rsp_data, ed);
      chk("done_id", rsp_id, g);
      chk("done_busy", busy, 1);
      for (int i = 0; i < bp; i++) begin
         step();
         chk("bp_valid", rsp_valid, 1);
         chk("bp_data", rsp_data, ed);
         chk("bp_id", rsp_id, g);
      end
      rsp_ready = 1'b1;
      #1;
      chk("hs_ready0", req0_ready, 0);
      chk("hs_ready1", req1_ready, 0);
      step();
      rsp_ready = 1'b0;
      chk("post_valid", rsp_valid, 0);
      chk("post_busy", busy, 0);
      chk("post_data", rsp_data, 0);
      m_last = g;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      req0_valid = 1'b0; req0_data = '0; req0_amt = '0;
      req1_valid = 1'b0; req1_data = '0; req1_amt = '0;
      rsp_ready = 1'b0;
      #1;
      chk("rst_valid", rsp_valid, 0);
      chk("rst_data", rsp_data, 0);
      chk("rst_id", rsp_id, 0);
      chk("rst_busy", busy, 0);
      step();
      step();
      @(negedge clk);
      rst_n = 1'b1;
      m_last = 1;

      // single job, amt 1
      do_job(1, 0, 8'b11010001, 8'h00, 3'd1, 3'd0, 0);
      // max shift on requester 1
      do_job(0, 1, 8'h00, 8'hD1, 3'd0, 3'd7, 0);
      // zero shift
      do_job(1, 0, 8'hA5, 8'h00, 3'd0, 3'd0, 0);

      // simultaneous requests straight after reset
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      m_last = 1;
      step();
      do_job(1, 1, 8'hF0, 8'hF0, 3'd2, 3'd3, 0);
      chk("sim_first_last", m_last, 0);
      do_job(1, 1, 8'hF0, 8'hF0, 3'd2, 3'd3, 0);
      chk("sim_second_last", m_last, 1);

      // backpressure for 5 cycles
      do_job(1, 0, 8'h5A, 8'h00, 3'd3, 3'd0, 5);

      // reset in the middle of an amt 7 job
      req1_valid = 1'b1; req1_data = 8'hFF; req1_amt = 3'd7;
      step();
      req1_valid = 1'b0;
      step();
      step();
      chk("midrst_busy_before", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", rsp_valid, 0);
      chk("midrst_data", rsp_data, 0);
      chk("midrst_id", rsp_id, 0);
      chk("midrst_busy", busy, 0);
      step();
      @(negedge clk);
      rst_n = 1'b1;
      m_last = 1;
      begin
         int seen;
         seen = 0;
         for (int i = 0; i < 12; i++) begin
            step();
            if (rsp_valid) seen++;
         end
         chk("midrst_no_rsp", seen, 0);
      end

      // random jobs
      for (int n = 0; n < 40; n++) begin
         bit rv0, rv1;
         rv0 = 1'($urandom_range(0, 1));
         rv1 = 1'($urandom_range(0, 1));
         if (!rv0 && !rv1) rv0 = 1'b1;
         do_job(rv0, rv1, 8'($urandom), 8'($urandom),
                3'($urandom), 3'($urandom), int'($urandom_range(0, 3)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/shift_sched.md
SHIFT_SCHED -- requirements
Module: shift_sched

Interface
REQ-001 The block SHALL have parameter W, default 8, giving the operand/result width in bits.
REQ-002 The block SHALL have parameter AMTW, default 3, giving the shift-amount width; W SHALL equal 2**AMTW.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req0_valid  input  1  requester 0 has a shift job.
REQ-006 req0_data  input  W  requester 0 operand.
REQ-007 req0_amt  input  AMTW  requester 0 logical right-shift amount.
REQ-008 req0_ready  output  1  requester 0 job accepted this cycle.
REQ-009 req1_valid, req1_data, req1_amt, req1_ready  SHALL mirror REQ-005..REQ-008 for requester 1.
REQ-010 rsp_valid  output  1  result available.
REQ-011 rsp_data  output  W  shifted result.
REQ-012 rsp_id  output  1  index of the requester that owns rsp_data.
REQ-013 rsp_ready  input  1  consumer accepts the result.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-016 The single shared datapath SHALL perform one 1-bit logical right shift per SHIFT cycle: data <= {1'b0, data[W-1:1]}.
REQ-017 In IDLE, reqN_ready SHALL be asserted combinationally only for the granted requester, and only when its valid is high; never both.
REQ-018 Arbitration SHALL be round-robin: with only one valid, grant it; with both valid, grant the one not granted last.
REQ-019 The last-grant pointer SHALL update only on a completed response handshake.
REQ-020 On acceptance (valid & ready, cycle T), the block SHALL capture data, amt and id into internal registers.
REQ-021 From IDLE: amt==0 -> DONE; amt!=0 -> SHIFT with the counter loaded to amt.
REQ-022 In SHIFT, each cycle SHALL shift once and decrement the counter; the transition to DONE SHALL occur on the cycle the counter goes from 1 to 0.
REQ-023 Latency: rsp_valid SHALL first assert in cycle T+1+amt (T+1 for amt==0).
REQ-024 In DONE, rsp_valid SHALL be 1, and rsp_data/rsp_id SHALL be held stable until rsp_ready is sampled high.
REQ-025 The DONE -> IDLE transition SHALL occur on rsp_valid & rsp_ready; no new job SHALL be accepted in that same cycle.
REQ-026 Requests arriving while busy SHALL be ignored (ready low), not queued; requesters hold valid.
REQ-027 rsp_valid SHALL be 0 in IDLE and SHIFT.
REQ-028 rsp_data SHALL be 0 in IDLE and SHIFT.

Reset
REQ-029 While rst_n is 0, the following SHALL hold asynchronously: state=IDLE, rsp_valid=0, rsp_data=0, rsp_id=0, busy=0, counter=0, last-grant=1 (requester 0 wins the first tie).
REQ-030 Reset asserted mid-SHIFT or in DONE SHALL abort the job; no response for it SHALL ever be produced.
REQ-031 After rst_n deasserts, the first arbitration SHALL occur on the first rising edge with rst_n high.

Verification
REQ-032 Single job: req0 data=8'b11010001, amt=1, rsp_ready=1 -> rsp_data=8'b01101000, rsp_id=0, rsp_valid at T+2.
REQ-033 Max shift: req1 data=8'hD1, amt=7 -> rsp_data=8'h01, rsp_id=1, rsp_valid at T+8; busy high T+1..T+8.
REQ-034 Zero shift: req0 data=8'hA5, amt=0 -> rsp_data=8'hA5 at T+1.
REQ-035 Simultaneous requests after reset: both valid, req0 amt=2 data=8'hF0, req1 amt=3 data=8'hF0 -> first rsp id=0 data=8'h3C; second rsp id=1 data=8'h1E.
REQ-036 Backpressure: rsp_ready held 0 for 5 cycles in DONE -> rsp_valid, rsp_data and rsp_id stable throughout; exactly one handshake occurs.
REQ-037 Reset mid-op: rst_n pulled low during SHIFT of an amt=7 job -> outputs at reset values immediately; no rsp_valid for that job.
